multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the 16-bit core over one shared instruction/data memory port.

---
 rtl/multicycle_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 16-bit core.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB over one
// shared memory port using a req/ack handshake, and drives the datapath
// strobes. Also counts retired instructions and flags memory timeouts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | stopped, waiting for start
// S_FETCH  | instruction read at PC, IR loads on ack
// S_DECODE | one cycle; HALT stops, NOP retires, others go to EXEC
// S_EXEC   | one ALU strobe; BEQ resolves and retires here
// S_MEM    | data access at ALU address (SW write / LW read)
// S_WB     | register write-back, PC advance, retire
// S_ERR    | memory timeout, only rst leaves
module multicycle_sequencer #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             eq_out,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             alu_add,
  output logic             alu_nand,
  output logic             alu_pass1,
  output logic             alu_eq,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_LUI  = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire;
  logic              timeout;

  // Retire and timeout conditions for the current cycle
  always_comb begin
    retire  = ((state == S_DECODE) && (opcode == OP_NOP)) ||
              ((state == S_EXEC) && (opcode == OP_BEQ)) ||
              ((state == S_MEM) && mem_ack && (opcode == OP_SW)) ||
              (state == S_WB);
    timeout = !mem_ack && (wait_cnt == WAIT_LAST);
  end

  // State sequencing, wait counter and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      if (retire) retired <= retired + 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ack)      state    <= S_DECODE;
          else if (timeout) state    <= S_ERR;
          else              wait_cnt <= wait_cnt + 1'b1;
        end
        S_DECODE: begin
          case (opcode)
            OP_HALT: state <= S_IDLE;
            OP_NOP: begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end
            default: state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (opcode)
            OP_ADD, OP_NAND, OP_LUI: state <= S_WB;
            OP_SW, OP_LW: begin
              state    <= S_MEM;
              wait_cnt <= '0;
            end
            default: begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (opcode == OP_SW) begin
              state    <= S_FETCH;
              wait_cnt <= '0;
            end else begin
              state <= S_WB;
            end
          end else if (timeout) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        default: state <= S_ERR;
      endcase
    end
  end

  // Output decode from the state register; ir_we, pc_we and pc_sel
  // follow mem_ack/eq_out directly so the datapath captures in the same cycle
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    alu_add   = 1'b0;
    alu_nand  = 1'b0;
    alu_pass1 = 1'b0;
    alu_eq    = 1'b0;
    busy      = 1'b0;
    err       = 1'b0;
    case (state)
      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        ir_we   = mem_ack;
      end
      S_DECODE: begin
        busy  = 1'b1;
        pc_we = (opcode == OP_NOP);
      end
      S_EXEC: begin
        busy = 1'b1;
        case (opcode)
          OP_ADD, OP_SW, OP_LW: alu_add   = 1'b1;
          OP_NAND:              alu_nand  = 1'b1;
          OP_LUI:               alu_pass1 = 1'b1;
          OP_BEQ: begin
            alu_eq = 1'b1;
            pc_we  = 1'b1;
            pc_sel = eq_out;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_SW);
        pc_we    = mem_ack && (opcode == OP_SW);
      end
      S_WB: begin
        busy   = 1'b1;
        reg_we = 1'b1;
        pc_we  = 1'b1;
        wb_sel = (opcode == OP_LW);
      end
      S_ERR: err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer. Expected per-cycle outputs are built
// from the instruction-level rules (phase lists per opcode and wait counts),
// then the design is driven with the same inputs and compared cycle by cycle.
module tb_multicycle_sequencer;

  localparam int WM = 16;

  localparam logic [13:0] REQ   = 14'h0001;
  localparam logic [13:0] WE    = 14'h0002;
  localparam logic [13:0] ASEL  = 14'h0004;
  localparam logic [13:0] IRWE  = 14'h0008;
  localparam logic [13:0] PCWE  = 14'h0010;
  localparam logic [13:0] PCSEL = 14'h0020;
  localparam logic [13:0] REGWE = 14'h0040;
  localparam logic [13:0] WBSEL = 14'h0080;
  localparam logic [13:0] ADD   = 14'h0100;
  localparam logic [13:0] NAND  = 14'h0200;
  localparam logic [13:0] PASS  = 14'h0400;
  localparam logic [13:0] ALEQ  = 14'h0800;
  localparam logic [13:0] BUSY  = 14'h1000;
  localparam logic [13:0] ERRB  = 14'h2000;

  logic clk, rst, start, eq_out, mem_ack;
  logic [2:0] opcode;
  logic mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, wb_sel;
  logic alu_add, alu_nand, alu_pass1, alu_eq, busy, err;
  logic [15:0] retired;
  logic w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we, w_pc_sel, w_reg_we, w_wb_sel;
  logic w_alu_add, w_alu_nand, w_alu_pass1, w_alu_eq, w_busy, w_err;
  logic [1:0] retired2;

  wire [13:0] outv = {err, busy, alu_eq, alu_pass1, alu_nand, alu_add, wb_sel,
                      reg_we, pc_sel, pc_we, ir_we, addr_sel, mem_we, mem_req};
  wire [13:0] w_outv = {w_err, w_busy, w_alu_eq, w_alu_pass1, w_alu_nand, w_alu_add, w_wb_sel,
                        w_reg_we, w_pc_sel, w_pc_we, w_ir_we, w_addr_sel, w_mem_we, w_mem_req};

  multicycle_sequencer #(.WAIT_MAX(WM), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .eq_out(eq_out),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_add(alu_add), .alu_nand(alu_nand), .alu_pass1(alu_pass1), .alu_eq(alu_eq),
    .busy(busy), .err(err), .retired(retired)
  );

  // Narrow-counter copy: shows the retired wrap without 65536 instructions
  multicycle_sequencer #(.WAIT_MAX(WM), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .eq_out(eq_out),
    .mem_ack(mem_ack), .mem_req(w_mem_req), .mem_we(w_mem_we), .addr_sel(w_addr_sel),
    .ir_we(w_ir_we), .pc_we(w_pc_we), .pc_sel(w_pc_sel), .reg_we(w_reg_we), .wb_sel(w_wb_sel),
    .alu_add(w_alu_add), .alu_nand(w_alu_nand), .alu_pass1(w_alu_pass1), .alu_eq(w_alu_eq),
    .busy(w_busy), .err(w_err), .retired(retired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       start;
    logic       ack;
    logic       eq;
    logic [2:0] op;
    logic [13:0] out;
    logic       ret;
  } cyc_t;

  cyc_t        q[$];
  logic [13:0] obs_out[$];
  logic [13:0] obs_w[$];
  logic [15:0] obs_ret[$];
  logic [1:0]  obs_ret2[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic void push_c(logic s, logic a, logic e, logic [2:0] o, logic [13:0] v, logic r);
    cyc_t c;
    c.start = s; c.ack = a; c.eq = e; c.op = o; c.out = v; c.ret = r;
    q.push_back(c);
  endfunction

  function automatic void idle(logic s);
    push_c(s, rb(), rb(), 3'($urandom_range(0, 7)), 14'h0, 1'b0);
  endfunction

  // Expected cycles of one instruction: fw/mw are request cycles without ack
  // before the ack; a count of WM or more means the memory never answers.
  function automatic void add_instr(logic [2:0] op, int fw, int mw, logic eq);
    logic [13:0] m;
    for (int k = 0; k < ((fw >= WM) ? WM : fw); k++) push_c(rb(), 1'b0, rb(), op, BUSY | REQ, 1'b0);
    if (fw >= WM) begin
      for (int k = 0; k < 3; k++) push_c(rb(), rb(), rb(), op, ERRB, 1'b0);
      return;
    end
    push_c(rb(), 1'b1, rb(), op, BUSY | REQ | IRWE, 1'b0);
    if (op == 3'd7) begin
      push_c(rb(), rb(), rb(), op, BUSY, 1'b0);
      return;
    end
    if (op == 3'd6) begin
      push_c(rb(), rb(), rb(), op, BUSY | PCWE, 1'b1);
      return;
    end
    push_c(rb(), rb(), rb(), op, BUSY, 1'b0);
    case (op)
      3'd3: begin
        push_c(rb(), rb(), eq, op, BUSY | ALEQ | PCWE | (eq ? PCSEL : 14'h0), 1'b1);
        return;
      end
      3'd1:    push_c(rb(), rb(), rb(), op, BUSY | NAND, 1'b0);
      3'd2:    push_c(rb(), rb(), rb(), op, BUSY | PASS, 1'b0);
      default: push_c(rb(), rb(), rb(), op, BUSY | ADD, 1'b0);
    endcase
    if (op == 3'd4 || op == 3'd5) begin
      m = BUSY | REQ | ASEL | ((op == 3'd4) ? WE : 14'h0);
      for (int k = 0; k < ((mw >= WM) ? WM : mw); k++) push_c(rb(), 1'b0, rb(), op, m, 1'b0);
      if (mw >= WM) begin
        for (int k = 0; k < 3; k++) push_c(rb(), rb(), rb(), op, ERRB, 1'b0);
        return;
      end
      if (op == 3'd4) begin
        push_c(rb(), 1'b1, rb(), op, m | PCWE, 1'b1);
        return;
      end
      push_c(rb(), 1'b1, rb(), op, m, 1'b0);
    end
    push_c(rb(), rb(), rb(), op, BUSY | REGWE | PCWE | ((op == 3'd5) ? WBSEL : 14'h0), 1'b1);
  endfunction

  function automatic void add_rand();
    int fw, mw;
    fw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, WM - 1) : $urandom_range(0, 2);
    mw = ($urandom_range(0, 7) == 0) ? $urandom_range(3, WM - 1) : $urandom_range(0, 2);
    add_instr(3'($urandom_range(0, 6)), fw, mw, rb());
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; eq_out = 1'b0; opcode = 3'd0;
    #3;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drives the queued inputs one per cycle and records outputs at the falling edge
  task automatic play();
    obs_out.delete(); obs_w.delete(); obs_ret.delete(); obs_ret2.delete();
    foreach (q[i]) begin
      start = q[i].start; mem_ack = q[i].ack; eq_out = q[i].eq; opcode = q[i].op;
      @(negedge clk);
      obs_out.push_back(outv);
      obs_w.push_back(w_outv);
      obs_ret.push_back(retired);
      obs_ret2.push_back(retired2);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mem_ack = 1'b1; eq_out = 1'b1; opcode = 3'd0;
    @(posedge clk);
    #1;
    checks++;
    if (outv !== 14'h0 || retired !== 16'd0) begin
      errors++;
      $display("FAIL reset_hold: out=%h ret=%0d, want out=0 ret=0", outv, retired);
    end
    do_reset();
    checks++;
    if (outv !== 14'h0 || retired !== 16'd0 || retired2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: out=%h ret=%0d ret2=%0d, want all 0", outv, retired, retired2);
    end
  endtask

  task automatic test_add();
    logic [15:0] er = 16'd0;
    do_reset();
    q.delete();
    idle(1'b1);
    add_instr(3'd0, 0, 0, 1'b0);
    play();
    foreach (q[i]) begin
      checks++;
      if (obs_out[i] !== q[i].out || obs_ret[i] !== er) begin
        errors++;
        $display("FAIL add cyc%0d: out=%h ret=%0d, want out=%h ret=%0d", i, obs_out[i], obs_ret[i], q[i].out, er);
      end
      if (q[i].ret) er++;
    end
    checks++;
    if (retired !== 16'd1) begin
      errors++;
      $display("FAIL add_retired: got %0d, want 1", retired);
    end
  endtask

  task automatic test_beq();
    logic [15:0] er = 16'd0;
    do_reset();
    q.delete();
    idle(1'b1);
    add_instr(3'd3, 0, 0, 1'b1);
    add_instr(3'd3, 1, 0, 1'b0);
    play();
    foreach (q[i]) begin
      checks++;
      if (obs_out[i] !== q[i].out || obs_ret[i] !== er) begin
        errors++;
        $display("FAIL beq cyc%0d: out=%h ret=%0d, want out=%h ret=%0d", i, obs_out[i], obs_ret[i], q[i].out, er);
      end
      if (q[i].ret) er++;
    end
    checks++;
    if (retired !== 16'd2) begin
      errors++;
      $display("FAIL beq_retired: got %0d, want 2", retired);
    end
  endtask

  task automatic test_lw_sw();
    logic [15:0] er = 16'd0;
    do_reset();
    q.delete();
    idle(1'b1);
    add_instr(3'd5, 0, 3, 1'b0);
    add_instr(3'd4, 0, 0, 1'b0);
    add_instr(3'd6, 0, 0, 1'b0);
    play();
    foreach (q[i]) begin
      checks++;
      if (obs_out[i] !== q[i].out || obs_ret[i] !== er) begin
        errors++;
        $display("FAIL lw_sw cyc%0d: out=%h ret=%0d, want out=%h ret=%0d", i, obs_out[i], obs_ret[i], q[i].out, er);
      end
      if (q[i].ret) er++;
    end
  endtask

  // Ack arriving in the last allowed request cycle, in both FETCH and MEM
  task automatic test_wait_boundary();
    logic [15:0] er = 16'd0;
    do_reset();
    q.delete();
    idle(1'b1);
    add_instr(3'd4, WM - 1, WM - 1, 1'b0);
    add_instr(3'd0, 1, 0, 1'b0);
    play();
    foreach (q[i]) begin
      checks++;
      if (obs_out[i] !== q[i].out || obs_ret[i] !== er) begin
        errors++;
        $display("FAIL wait_edge cyc%0d: out=%h ret=%0d, want out=%h ret=%0d", i, obs_out[i], obs_ret[i], q[i].out, er);
      end
      if (q[i].ret) er++;
    end
  endtask

  task automatic test_timeout();
    logic [15:0] er;
    for (int p = 0; p < 2; p++) begin
      er = 16'd0;
      do_reset();
      q.delete();
      idle(1'b1);
      if (p == 0) add_instr(3'd0, WM, 0, 1'b0);
      else begin
        add_instr(3'd6, 0, 0, 1'b0);
        add_instr(3'd5, 0, WM, 1'b0);
      end
      play();
      foreach (q[i]) begin
        checks++;
        if (obs_out[i] !== q[i].out || obs_ret[i] !== er) begin
          errors++;
          $display("FAIL timeout%0d cyc%0d: out=%h ret=%0d, want out=%h ret=%0d", p, i, obs_out[i], obs_ret[i], q[i].out, er);
        end
        if (q[i].ret) er++;
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] er = 16'd0;
    do_reset();
    q.delete();
    idle(1'b1);
    for (int k = 0; k < 5; k++) add_rand();
    add_instr(3'd7, $urandom_range(0, 2), 0, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0);
    play();
    foreach (q[i]) begin
      checks++;
      if (obs_out[i] !== q[i].out || obs_ret[i] !== er) begin
        errors++;
        $display("FAIL halt cyc%0d: out=%h ret=%0d, want out=%h ret=%0d", i, obs_out[i], obs_ret[i], q[i].out, er);
      end
      if (q[i].ret) er++;
    end
    checks++;
    if (retired !== 16'd5) begin
      errors++;
      $display("FAIL halt_retired: got %0d, want 5", retired);
    end
  endtask

  task automatic test_random();
    logic [15:0] er = 16'd0;
    do_reset();
    q.delete();
    idle(1'b1);
    for (int k = 0; k < 40; k++) add_rand();
    add_instr(3'd7, 0, 0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    for (int k = 0; k < 20; k++) add_rand();
    play();
    foreach (q[i]) begin
      checks++;
      if (obs_out[i] !== q[i].out || obs_ret[i] !== er) begin
        errors++;
        $display("FAIL random cyc%0d: out=%h ret=%0d, want out=%h ret=%0d", i, obs_out[i], obs_ret[i], q[i].out, er);
      end
      if (q[i].ret) er++;
    end
  endtask

  task automatic test_wrap();
    logic [1:0] er = 2'd0;
    do_reset();
    q.delete();
    idle(1'b1);
    for (int k = 0; k < 5; k++) add_instr(3'd6, $urandom_range(0, 1), 0, 1'b0);
    play();
    foreach (q[i]) begin
      checks++;
      if (obs_w[i] !== q[i].out || obs_ret2[i] !== er) begin
        errors++;
        $display("FAIL wrap cyc%0d: out=%h ret=%0d, want out=%h ret=%0d", i, obs_w[i], obs_ret2[i], q[i].out, er);
      end
      if (q[i].ret) er++;
    end
    checks++;
    if (retired2 !== 2'd1) begin
      errors++;
      $display("FAIL wrap_final: got %0d, want 1", retired2);
    end
  endtask

  task automatic test_rst_mid_mem();
    do_reset();
    q.delete();
    idle(1'b1);
    add_instr(3'd6, 0, 0, 1'b0);
    add_instr(3'd5, 0, 0, 1'b0);
    void'(q.pop_back());
    void'(q.pop_back());
    play();
    mem_ack = 1'b0; opcode = 3'd5;
    #2;
    checks++;
    if (outv !== (BUSY | REQ | ASEL) || retired !== 16'd1) begin
      errors++;
      $display("FAIL mid_mem: out=%h ret=%0d, want out=%h ret=1", outv, retired, BUSY | REQ | ASEL);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outv !== 14'h0 || retired !== 16'd0) begin
      errors++;
      $display("FAIL async_rst: out=%h ret=%0d, want out=0 ret=0", outv, retired);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_ack = 1'b0; eq_out = 1'b0; opcode = 3'd0;
    test_reset();
    test_add();
    test_beq();
    test_lw_sw();
    test_wait_boundary();
    test_timeout();
    test_halt();
    test_wrap();
    test_rst_mid_mem();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
